// File: rtl/reg_sequencer.sv
// reg_sequencer: instruction sequencer for the relay computer's register unit.
// Fetches an instruction byte (F1/F2) and then steps a per-class execute
// micro-sequence of one-hot Moore strobes for the register unit control bus.
// Optional feature macro: SEQ_INCXY_EN adds the INC XY opcode (10110000).
module reg_sequencer #(
    parameter int WR_SETUP = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       go,
    input  logic [7:0] data_in,
    output logic [7:0] ld8,
    output logic [7:0] sel8,
    output logic [7:0] imm,
    output logic       sel_imm,
    output logic [2:0] alu_fn,
    output logic       sel_alu,
    output logic       ld_flags,
    output logic       sel_pc,
    output logic       ld_pc,
    output logic       sel_m,
    output logic       sel_xy,
    output logic       ld_xy,
    output logic       sel_inc,
    output logic       ld_inc,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       busy,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_F1,
        S_F2,
        S_E1,
        S_E2,
        S_E3,
        S_E4,
        S_HALTED
    } state_t;

    typedef enum logic [3:0] {
        OP_MOV8,
        OP_SETAB,
        OP_ALU,
        OP_LOAD,
        OP_STORE,
        OP_MOV16,
        OP_HALT,
        OP_INCXY,
        OP_NOP
    } op_t;

    // STORE uses E1 for the address/data setup cycles, E2 for the write
    // cycle and E3 for the hold cycles; cnt_q counts within E1 and E3.
    localparam bit         HAS_SETUP    = (WR_SETUP != 0);
    localparam int         SETUP_LAST_I = (WR_SETUP > 0) ? (WR_SETUP - 1) : 0;
    localparam logic [1:0] SETUP_LAST   = SETUP_LAST_I[1:0];

    state_t     state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic [1:0] cnt_q, cnt_d;
    op_t        op;
    logic       ld_inst;

    // Classify the instruction register into an execute class.
    always_comb begin
        op = OP_NOP;
        if (ir_q[7:6] == 2'b00) begin
            op = OP_MOV8;
        end else if (ir_q[7:6] == 2'b01) begin
            op = OP_SETAB;
        end else if (ir_q[7:4] == 4'b1000) begin
            op = OP_ALU;
        end else if (ir_q[7:2] == 6'b100100) begin
            op = OP_LOAD;
        end else if (ir_q[7:2] == 6'b100110) begin
            op = OP_STORE;
        end else if (ir_q[7:4] == 4'b1010 && ir_q[1:0] == 2'b00) begin
            op = OP_MOV16;
        end else if (ir_q == 8'hAE) begin
            op = OP_HALT;
`ifdef SEQ_INCXY_EN
        end else if (ir_q == 8'hB0) begin
            op = OP_INCXY;
`endif
        end
    end

    // Next-state, instruction register load and Moore strobe decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ld_inst  = 1'b0;
        ld8      = 8'h00;
        sel8     = 8'h00;
        imm      = 8'h00;
        sel_imm  = 1'b0;
        alu_fn   = 3'b000;
        sel_alu  = 1'b0;
        ld_flags = 1'b0;
        sel_pc   = 1'b0;
        ld_pc    = 1'b0;
        sel_m    = 1'b0;
        sel_xy   = 1'b0;
        ld_xy    = 1'b0;
        sel_inc  = 1'b0;
        ld_inc   = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;

        case (state_q)
            S_IDLE, S_HALTED: begin
                if (go) begin
                    state_d = S_F1;
                end
            end
            S_F1: begin
                sel_pc  = 1'b1;
                mem_rd  = 1'b1;
                ld_inst = 1'b1;
                ld_inc  = 1'b1;
                state_d = S_F2;
            end
            S_F2: begin
                sel_inc = 1'b1;
                ld_pc   = 1'b1;
                cnt_d   = 2'd0;
                if (op == OP_STORE && !HAS_SETUP) begin
                    state_d = S_E2;
                end else begin
                    state_d = S_E1;
                end
            end
            S_E1: begin
                state_d = S_F1;
                case (op)
                    OP_MOV8: begin
                        sel8[ir_q[2:0]] = 1'b1;
                        ld8[ir_q[5:3]]  = 1'b1;
                    end
                    OP_SETAB: begin
                        sel_imm = 1'b1;
                        imm     = {{3{ir_q[4]}}, ir_q[4:0]};
                        ld8     = ir_q[5] ? 8'h02 : 8'h01;
                    end
                    OP_ALU: begin
                        alu_fn   = ir_q[2:0];
                        sel_alu  = 1'b1;
                        ld_flags = 1'b1;
                        ld8      = ir_q[3] ? 8'h08 : 8'h01;
                    end
                    OP_LOAD: begin
                        sel_m           = 1'b1;
                        mem_rd          = 1'b1;
                        ld8[ir_q[1:0]]  = 1'b1;
                    end
                    OP_STORE: begin
                        sel_m           = 1'b1;
                        sel8[ir_q[1:0]] = 1'b1;
                        if (cnt_q == SETUP_LAST) begin
                            cnt_d   = 2'd0;
                            state_d = S_E2;
                        end else begin
                            cnt_d   = cnt_q + 2'd1;
                            state_d = S_E1;
                        end
                    end
                    OP_MOV16: begin
                        sel_xy = ir_q[2];
                        sel_m  = ~ir_q[2];
                        ld_pc  = ir_q[3];
                        ld_xy  = ~ir_q[3];
                    end
                    OP_HALT: begin
                        state_d = S_HALTED;
                    end
                    OP_INCXY: begin
                        sel_xy  = 1'b1;
                        ld_inc  = 1'b1;
                        state_d = S_E2;
                    end
                    default: begin
                        state_d = S_F1;
                    end
                endcase
            end
            S_E2: begin
                state_d = S_F1;
                if (op == OP_STORE) begin
                    sel_m           = 1'b1;
                    sel8[ir_q[1:0]] = 1'b1;
                    mem_wr          = 1'b1;
                    if (HAS_SETUP) begin
                        cnt_d   = 2'd0;
                        state_d = S_E3;
                    end
                end else if (op == OP_INCXY) begin
                    sel_inc = 1'b1;
                    ld_xy   = 1'b1;
                end
            end
            S_E3: begin
                state_d = S_F1;
                if (op == OP_STORE) begin
                    sel_m           = 1'b1;
                    sel8[ir_q[1:0]] = 1'b1;
                    if (cnt_q != SETUP_LAST) begin
                        cnt_d   = cnt_q + 2'd1;
                        state_d = S_E3;
                    end
                end
            end
            default: begin
                state_d = S_F1;
            end
        endcase

        busy   = (state_q != S_IDLE) && (state_q != S_HALTED);
        halted = (state_q == S_HALTED);
    end

    // Instruction register captures the data bus during F1.
    always_comb begin
        ir_d = ld_inst ? data_in : ir_q;
    end

    // State, instruction register and step counter; reset aborts to IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ir_q    <= 8'h00;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_reg_sequencer.sv
// Testbench for reg_sequencer: directed opcodes from the test plan followed
// by random opcodes, compared cycle by cycle against a behavioural model.
module tb_reg_sequencer;

    localparam int WS = 1;

    typedef struct packed {
        logic [7:0] ld8;
        logic [7:0] sel8;
        logic [7:0] imm;
        logic       sel_imm;
        logic [2:0] alu_fn;
        logic       sel_alu;
        logic       ld_flags;
        logic       sel_pc;
        logic       ld_pc;
        logic       sel_m;
        logic       sel_xy;
        logic       ld_xy;
        logic       sel_inc;
        logic       ld_inc;
        logic       mem_rd;
        logic       mem_wr;
        logic       busy;
        logic       halted;
    } strobes_t;

    logic       clk;
    logic       reset_n;
    logic       go;
    logic [7:0] data_in;
    logic [7:0] ld8, sel8, imm;
    logic       sel_imm, sel_alu, ld_flags;
    logic [2:0] alu_fn;
    logic       sel_pc, ld_pc, sel_m, sel_xy, ld_xy, sel_inc, ld_inc;
    logic       mem_rd, mem_wr, busy, halted;

    strobes_t   obs;
    strobes_t   exp_q[$];
    int         tests_run = 0;
    int         tests_failed = 0;

    reg_sequencer #(.WR_SETUP(WS)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .go       (go),
        .data_in  (data_in),
        .ld8      (ld8),
        .sel8     (sel8),
        .imm      (imm),
        .sel_imm  (sel_imm),
        .alu_fn   (alu_fn),
        .sel_alu  (sel_alu),
        .ld_flags (ld_flags),
        .sel_pc   (sel_pc),
        .ld_pc    (ld_pc),
        .sel_m    (sel_m),
        .sel_xy   (sel_xy),
        .ld_xy    (ld_xy),
        .sel_inc  (sel_inc),
        .ld_inc   (ld_inc),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .busy     (busy),
        .halted   (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Gather all DUT outputs into one vector for comparison.
    always_comb begin
        obs          = '0;
        obs.ld8      = ld8;
        obs.sel8     = sel8;
        obs.imm      = imm;
        obs.sel_imm  = sel_imm;
        obs.alu_fn   = alu_fn;
        obs.sel_alu  = sel_alu;
        obs.ld_flags = ld_flags;
        obs.sel_pc   = sel_pc;
        obs.ld_pc    = ld_pc;
        obs.sel_m    = sel_m;
        obs.sel_xy   = sel_xy;
        obs.ld_xy    = ld_xy;
        obs.sel_inc  = sel_inc;
        obs.ld_inc   = ld_inc;
        obs.mem_rd   = mem_rd;
        obs.mem_wr   = mem_wr;
        obs.busy     = busy;
        obs.halted   = halted;
    end

    task automatic checkOutput(input string tag, input strobes_t observed, input strobes_t expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference model: list of execute-cycle strobe vectors for one opcode.
    task automatic modelInstr(input logic [7:0] op);
        strobes_t s;
        int       v;
        exp_q.delete();
        s      = '0;
        s.busy = 1'b1;
        if (op < 8'h40) begin
            s.ld8  = 8'(1 << op[5:3]);
            s.sel8 = 8'(1 << op[2:0]);
            s.sel8 = s.sel8 | 8'(1 << op[2:0]);
            exp_q.push_back(s);
        end else if (op < 8'h80) begin
            v = int'(op[4:0]);
            if (v >= 16) v = v - 32;
            s.sel_imm = 1'b1;
            s.imm     = 8'(v);
            s.ld8     = op[5] ? 8'd2 : 8'd1;
            exp_q.push_back(s);
        end else if (op < 8'h90) begin
            s.alu_fn   = 3'(op % 8);
            s.sel_alu  = 1'b1;
            s.ld_flags = 1'b1;
            s.ld8      = op[3] ? 8'd8 : 8'd1;
            exp_q.push_back(s);
        end else if (op >= 8'h90 && op <= 8'h93) begin
            s.sel_m  = 1'b1;
            s.mem_rd = 1'b1;
            s.ld8    = 8'(1 << (op % 4));
            exp_q.push_back(s);
        end else if (op >= 8'h98 && op <= 8'h9B) begin
            for (int k = 0; k <= 2 * WS; k++) begin
                s        = '0;
                s.busy   = 1'b1;
                s.sel_m  = 1'b1;
                s.sel8   = 8'(1 << (op % 4));
                s.mem_wr = (k == WS);
                exp_q.push_back(s);
            end
        end else if ((op & 8'hF3) == 8'hA0) begin
            s.sel_xy = op[2];
            s.sel_m  = !op[2];
            s.ld_pc  = op[3];
            s.ld_xy  = !op[3];
            exp_q.push_back(s);
`ifdef SEQ_INCXY_EN
        end else if (op == 8'hB0) begin
            s.sel_xy = 1'b1;
            s.ld_inc = 1'b1;
            exp_q.push_back(s);
            s        = '0;
            s.busy   = 1'b1;
            s.sel_inc = 1'b1;
            s.ld_xy  = 1'b1;
            exp_q.push_back(s);
`endif
        end else begin
            exp_q.push_back(s);
        end
    endtask

    function automatic strobes_t fetch1();
        strobes_t s;
        s        = '0;
        s.busy   = 1'b1;
        s.sel_pc = 1'b1;
        s.mem_rd = 1'b1;
        s.ld_inc = 1'b1;
        return s;
    endfunction

    function automatic strobes_t fetch2();
        strobes_t s;
        s         = '0;
        s.busy    = 1'b1;
        s.sel_inc = 1'b1;
        s.ld_pc   = 1'b1;
        return s;
    endfunction

    function automatic strobes_t haltedState();
        strobes_t s;
        s        = '0;
        s.halted = 1'b1;
        return s;
    endfunction

    // Runs one instruction starting at the negedge inside its F1 cycle and
    // returns at the negedge of the following cycle.
    task automatic applyStimulus(input logic [7:0] op);
        modelInstr(op);
        data_in = op;
        checkOutput($sformatf("F1 op=%h", op), obs, fetch1());
        go = 1'($urandom);
        @(negedge clk);
        data_in = 8'($urandom);
        checkOutput($sformatf("F2 op=%h", op), obs, fetch2());
        @(negedge clk);
        for (int k = 0; k < exp_q.size(); k++) begin
            checkOutput($sformatf("E%0d op=%h", k + 1, op), obs, exp_q[k]);
            go = (op == 8'hAE) ? 1'b1 : 1'($urandom);
            @(negedge clk);
        end
        if (op == 8'hAE) begin
            go = 1'b0;
            for (int k = 0; k < 2; k++) begin
                checkOutput("halted", obs, haltedState());
                @(negedge clk);
            end
            go = 1'b1;
            @(negedge clk);
            go = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] directed[10];
        logic [7:0] op;
        directed = '{8'h0A, 8'h5F, 8'h83, 8'h9A, 8'hAE, 8'hB0, 8'h1B, 8'hA4, 8'hA8, 8'h92};

        reset_n = 1'b0;
        go      = 1'b0;
        data_in = 8'h00;
        repeat (2) @(negedge clk);
        checkOutput("reset", obs, '0);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("idle", obs, '0);
        go = 1'b1;
        @(negedge clk);

        foreach (directed[i]) applyStimulus(directed[i]);

        // Reset during the write cycle of a STORE aborts immediately.
        modelInstr(8'h98);
        data_in = 8'h98;
        go      = 1'b0;
        checkOutput("rst F1", obs, fetch1());
        @(negedge clk);
        checkOutput("rst F2", obs, fetch2());
        @(negedge clk);
        checkOutput("rst E1", obs, exp_q[0]);
        @(negedge clk);
        checkOutput("rst E2", obs, exp_q[1]);
        reset_n = 1'b0;
        #1;
        checkOutput("rst abort", obs, '0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("rst idle", obs, '0);
        end
        go = 1'b1;
        @(negedge clk);

        for (int n = 0; n < 80; n++) begin
            op = 8'($urandom);
            applyStimulus(op);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
